// File: rtl/bench_pkg.sv
// Shared constants for the MCS8 bench ROM responder: halt opcodes, FSM states,
// counter widths and the debug view of the responder's internal state.
package bench_pkg;

  localparam logic [7:0] OP_HLT0 = 8'h00;
  localparam logic [7:0] OP_HLT1 = 8'h01;
  localparam logic [7:0] OP_HLT2 = 8'hFF;

  localparam int FETCH_CNT_W = 32;
  localparam int WAIT_CNT_W  = 4;
  localparam int HALT_RUN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } romState_t;

  typedef struct packed {
    romState_t               state;
    logic [WAIT_CNT_W-1:0]   waitCnt;
    logic [HALT_RUN_W-1:0]   haltRun;
    logic                    fileImage;
  } romDbg_t;

endpackage

// File: rtl/bench_wait_counter.sv
// Wait-state counter: cleared when a fetch is accepted, counts while the
// responder waits, and flags done once it reaches WAIT_STATES.
module bench_wait_counter
  import bench_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  inc,
  output logic [WAIT_CNT_W-1:0] count,
  output logic                  done
);

  assign done = (count == WAIT_CNT_W'(WAIT_STATES));

  // Holding at the target keeps the counter from wrapping if inc lingers.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (inc && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bench_rom_model.sv
// Instruction-ROM responder for MCS8 CPU benches: REQ/ACK fetches with
// programmable wait states, out-of-range flagging, fetch counting, halt detect.
module bench_rom_model
  import bench_pkg::*;
#(
  parameter int              AW          = 14,
  parameter int              DW          = 8,
  parameter int              DEPTH       = 16384,
  parameter int              WAIT_STATES = 0,
  parameter logic [DW-1:0]   FILL_WORD   = 8'hFF,
  parameter logic [DW-1:0]   HALT_OPCODE = OP_HLT0,
  parameter int              HALT_REPEAT = 2,
  parameter string           INIT_FILE   = "rom.hex"
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   REQ_I,
  input  logic [AW-1:0]          ADDR_I,
  output logic [DW-1:0]          DAT_O,
  output logic                   ACK_O,
  output logic                   BUSY_O,
  output logic                   ERR_O,
  output logic                   HALT_O,
  output logic [FETCH_CNT_W-1:0] FETCH_CNT_O,
  output romDbg_t                DBG_O
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [HALT_RUN_W-1:0] HALT_TARGET = HALT_RUN_W'(HALT_REPEAT);

  if (DEPTH < 1 || DEPTH > (1 << AW)) begin : gBadDepth
    $error("bench_rom_model: DEPTH %0d does not fit AW=%0d", DEPTH, AW);
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : gBadWait
    $error("bench_rom_model: WAIT_STATES %0d outside 0..15", WAIT_STATES);
  end
  if (HALT_REPEAT < 1 || HALT_REPEAT > 255) begin : gBadHalt
    $error("bench_rom_model: HALT_REPEAT %0d outside 1..255", HALT_REPEAT);
  end

  // Read-only image; the enclosing bench deposits INIT_FILE contents here.
  logic [DW-1:0] mem [2**IW] = '{default: FILL_WORD};

  romState_t               state;
  romState_t               stateNext;
  logic                    accept;
  logic [AW-1:0]           addrQ;
  logic                    waitDone;
  logic [WAIT_CNT_W-1:0]   waitCount;
  logic                    inRange;
  logic [DW-1:0]           rdData;
  logic [HALT_RUN_W-1:0]   haltRun;
  logic [HALT_RUN_W-1:0]   haltRunNext;
  logic [FETCH_CNT_W-1:0]  fetchCnt;

  bench_wait_counter #(
    .WAIT_STATES(WAIT_STATES)
  ) uWaitCounter (
    .clk  (CLK_I),
    .rst  (RST_I),
    .load (accept),
    .inc  (state == ST_WAIT),
    .count(waitCount),
    .done (waitDone)
  );

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (REQ_I) begin
          accept    = 1'b1;
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (waitDone) stateNext = ST_ACK;
      end
      ST_ACK: begin
        accept    = REQ_I;
        stateNext = REQ_I ? ST_WAIT : ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign inRange = (32'(addrQ) < 32'(DEPTH));
  assign rdData  = inRange ? mem[addrQ[IW-1:0]] : FILL_WORD;

  // The halt rule looks at returned data, so fill words can extend a run.
  always_comb begin
    haltRunNext = '0;
    if (rdData == HALT_OPCODE) begin
      haltRunNext = (haltRun == HALT_TARGET) ? haltRun : haltRun + 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= ST_IDLE;
      addrQ <= '0;
      ACK_O <= 1'b0;
    end else begin
      state <= stateNext;
      ACK_O <= (state == ST_ACK);
      if (accept) addrQ <= ADDR_I;
    end
  end

  // Completion side effects happen on the edge that raises ACK_O.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      DAT_O    <= '0;
      ERR_O    <= 1'b0;
      HALT_O   <= 1'b0;
      haltRun  <= '0;
      fetchCnt <= '0;
    end else if (state == ST_ACK) begin
      DAT_O   <= rdData;
      haltRun <= haltRunNext;
      if (fetchCnt != '1) fetchCnt <= fetchCnt + 1'b1;
      if (!inRange) ERR_O <= 1'b1;
      if (haltRunNext == HALT_TARGET) HALT_O <= 1'b1;
    end
  end

  assign BUSY_O      = (state == ST_WAIT) || (state == ST_ACK);
  assign FETCH_CNT_O = fetchCnt;
  assign DBG_O       = '{state: state, waitCnt: waitCount, haltRun: haltRun,
                         fileImage: (INIT_FILE != "")};

endmodule

// File: tb/tb_bench_rom_model.sv
// Bench for bench_rom_model: two instances (zero-wait/256-deep and three-wait/
// full-depth) checked against a fetch-level reference model.
module tb_bench_rom_model;
  import bench_pkg::*;

  localparam int AW = 14;
  localparam int W0 = 0;
  localparam int W1 = 3;
  localparam int D0 = 256;
  localparam int D1 = 16384;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst;
  logic [1:0]          req;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][7:0]     dat;
  logic [1:0]          ack;
  logic [1:0]          busy;
  logic [1:0]          err;
  logic [1:0]          halt;
  logic [1:0][31:0]    cnt;
  romDbg_t             dbg0;
  romDbg_t             dbg1;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0]     refMem [D1];
  logic [7:0]     exp_q[$];
  logic [AW-1:0]  seq_q[$];
  logic [31:0]    mCnt  [2];
  logic           mErr  [2];
  logic           mHalt [2];
  int             mRun  [2];

  bench_rom_model #(
    .AW(AW), .DW(8), .DEPTH(D0), .WAIT_STATES(W0), .FILL_WORD(8'hFF),
    .HALT_OPCODE(8'h00), .HALT_REPEAT(2), .INIT_FILE("")
  ) dut0 (
    .CLK_I(clk), .RST_I(rst[0]), .REQ_I(req[0]), .ADDR_I(addr[0]),
    .DAT_O(dat[0]), .ACK_O(ack[0]), .BUSY_O(busy[0]), .ERR_O(err[0]),
    .HALT_O(halt[0]), .FETCH_CNT_O(cnt[0]), .DBG_O(dbg0)
  );

  bench_rom_model #(
    .AW(AW), .DW(8), .DEPTH(D1), .WAIT_STATES(W1), .FILL_WORD(8'hFF),
    .HALT_OPCODE(8'h00), .HALT_REPEAT(2), .INIT_FILE("")
  ) dut1 (
    .CLK_I(clk), .RST_I(rst[1]), .REQ_I(req[1]), .ADDR_I(addr[1]),
    .DAT_O(dat[1]), .ACK_O(ack[1]), .BUSY_O(busy[1]), .ERR_O(err[1]),
    .HALT_O(halt[1]), .FETCH_CNT_O(cnt[1]), .DBG_O(dbg1)
  );

  function automatic logic [7:0] exp_data(input int s, input logic [AW-1:0] a);
    int d;
    d = (s == 0) ? D0 : D1;
    return (int'(a) < d) ? refMem[a] : 8'hFF;
  endfunction

  task automatic model_reset(input int s);
    mCnt[s]  = '0;
    mErr[s]  = 1'b0;
    mHalt[s] = 1'b0;
    mRun[s]  = 0;
  endtask

  task automatic model_fetch(input int s, input logic [AW-1:0] a, input logic [7:0] d);
    int depth;
    depth = (s == 0) ? D0 : D1;
    if (mCnt[s] != 32'hFFFF_FFFF) mCnt[s] = mCnt[s] + 1;
    if (int'(a) >= depth) mErr[s] = 1'b1;
    if (d == 8'h00) mRun[s] = (mRun[s] < 2) ? mRun[s] + 1 : 2;
    else            mRun[s] = 0;
    if (mRun[s] == 2) mHalt[s] = 1'b1;
  endtask

  // driver tasks
  task automatic fill_image();
    for (int i = 0; i < D1; i++) refMem[i] = 8'($urandom_range(0, 255));
    refMem[0] = 8'h3E;
    refMem[4] = 8'h00;
    refMem[5] = 8'h00;
    refMem[6] = 8'h3E;
    for (int i = 0; i < D1; i++) dut1.mem[i] = refMem[i];
    for (int i = 0; i < D0; i++) dut0.mem[i] = refMem[i];
  endtask

  task automatic pulse_reset(input int s);
    @(negedge clk);
    rst[s] = 1'b1;
    req[s] = 1'b0;
    @(negedge clk);
    rst[s] = 1'b0;
    model_reset(s);
  endtask

  task automatic present(input int s, input int j);
    if (j < seq_q.size()) addr[s] = seq_q[j];
    else                  req[s]  = 1'b0;
  endtask

  // Issues seq_q as one request stream (REQ held between fetches) and scores every ACK.
  task automatic run_seq(input int s);
    int n, k, cyc, lat;
    logic [AW-1:0] a;
    logic [7:0] e;
    n   = seq_q.size();
    lat = ((s == 0) ? W0 : W1) + 2;
    exp_q.delete();
    foreach (seq_q[i]) exp_q.push_back(exp_data(s, seq_q[i]));
    req[s]  = 1'b1;
    addr[s] = seq_q[0];
    k   = 0;
    cyc = -1;
    while (k < n) begin
      @(negedge clk);
      cyc++;
      if (k == 0 && cyc == 0) present(s, 1);
      if (ack[s] === 1'b1) begin
        a = seq_q[k];
        e = exp_q.pop_front();
        vectors++;
        if (cyc !== lat) begin
          miscompares++;
          $display("FAIL latency dut%0d fetch %0d: got %0d cycles, expected %0d", s, k, cyc, lat);
        end
        vectors++;
        if (dat[s] !== e) begin
          miscompares++;
          $display("FAIL data dut%0d addr %h: got %h, expected %h", s, a, dat[s], e);
        end
        model_fetch(s, a, e);
        vectors++;
        if (cnt[s] !== mCnt[s]) begin
          miscompares++;
          $display("FAIL fetch_cnt dut%0d: got %h, expected %h", s, cnt[s], mCnt[s]);
        end
        vectors++;
        if (err[s] !== mErr[s]) begin
          miscompares++;
          $display("FAIL err dut%0d addr %h: got %b, expected %b", s, a, err[s], mErr[s]);
        end
        vectors++;
        if (halt[s] !== mHalt[s]) begin
          miscompares++;
          $display("FAIL halt dut%0d addr %h: got %b, expected %b", s, a, halt[s], mHalt[s]);
        end
        if (k + 1 < n) present(s, k + 2);
        k++;
        cyc = 0;
      end else if (cyc > lat + 8) begin
        vectors++;
        miscompares++;
        $display("FAIL ack_timeout dut%0d fetch %0d: no ACK after %0d cycles, expected %0d", s, k, cyc, lat);
        req[s] = 1'b0;
        return;
      end
    end
    @(negedge clk);
    vectors++;
    if (ack[s] !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_one_cycle dut%0d: got %b, expected 0", s, ack[s]);
    end
  endtask

  // scenarios
  task automatic test_reset();
    romState_t st;
    @(negedge clk);
    fill_image();
    @(negedge clk);
    rst = 2'b00;
    model_reset(0);
    model_reset(1);
    for (int s = 0; s < 2; s++) begin
      st = (s == 0) ? dbg0.state : dbg1.state;
      vectors += 7;
      if (dat[s]  !== 8'h00)  begin miscompares++; $display("FAIL reset_dat dut%0d: got %h, expected 00", s, dat[s]); end
      if (ack[s]  !== 1'b0)   begin miscompares++; $display("FAIL reset_ack dut%0d: got %b, expected 0", s, ack[s]); end
      if (busy[s] !== 1'b0)   begin miscompares++; $display("FAIL reset_busy dut%0d: got %b, expected 0", s, busy[s]); end
      if (err[s]  !== 1'b0)   begin miscompares++; $display("FAIL reset_err dut%0d: got %b, expected 0", s, err[s]); end
      if (halt[s] !== 1'b0)   begin miscompares++; $display("FAIL reset_halt dut%0d: got %b, expected 0", s, halt[s]); end
      if (cnt[s]  !== 32'h0)  begin miscompares++; $display("FAIL reset_cnt dut%0d: got %h, expected 0", s, cnt[s]); end
      if (st !== ST_IDLE)     begin miscompares++; $display("FAIL reset_state dut%0d: got %0d, expected IDLE", s, st); end
    end
  endtask

  task automatic test_single_fetch();
    seq_q = '{14'h0000};
    run_seq(0);
    vectors++;
    if (cnt[0] !== 32'd1) begin
      miscompares++;
      $display("FAIL single_cnt: got %0d, expected 1", cnt[0]);
    end
  endtask

  task automatic test_back_to_back();
    int busyGaps;
    pulse_reset(1);
    seq_q = '{14'h0000, 14'h0001, 14'h0002};
    busyGaps = 0;
    fork
      run_seq(1);
      repeat (14) begin
        @(negedge clk);
        if (busy[1] !== 1'b1) busyGaps++;
      end
    join
    vectors++;
    if (busyGaps != 0) begin
      miscompares++;
      $display("FAIL b2b_busy_gap: got %0d idle cycles, expected 0", busyGaps);
    end
    vectors++;
    if (cnt[1] !== 32'd3) begin
      miscompares++;
      $display("FAIL b2b_cnt: got %0d, expected 3", cnt[1]);
    end
  endtask

  task automatic test_out_of_range();
    pulse_reset(0);
    seq_q = '{14'h0100, 14'h0005, 14'h00FF};
    run_seq(0);
    seq_q = '{14'h3FFF, 14'h0000};
    run_seq(0);
    vectors++;
    if (err[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, expected 1", err[0]);
    end
  endtask

  task automatic test_halt();
    pulse_reset(1);
    seq_q = '{14'h0004, 14'h0006, 14'h0005};
    run_seq(1);
    pulse_reset(1);
    seq_q = '{14'h0004, 14'h0005, 14'h0006};
    run_seq(1);
    vectors++;
    if (halt[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_sticky: got %b, expected 1", halt[1]);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic sawAck;
    pulse_reset(1);
    req[1]  = 1'b1;
    addr[1] = 14'h0006;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    model_reset(1);
    vectors += 3;
    if (busy[1] !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b, expected 0", busy[1]); end
    if (ack[1]  !== 1'b0) begin miscompares++; $display("FAIL abort_ack: got %b, expected 0", ack[1]); end
    if (cnt[1]  !== 32'h0) begin miscompares++; $display("FAIL abort_cnt: got %0d, expected 0", cnt[1]); end
    sawAck = 1'b0;
    repeat (8) begin
      @(negedge clk);
      sawAck |= ack[1];
    end
    vectors++;
    if (sawAck !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_ack: got %b, expected 0", sawAck);
    end
    seq_q = '{14'h0006};
    run_seq(1);
  endtask

  task automatic test_saturate();
    pulse_reset(1);
    dut1.fetchCnt = 32'hFFFF_FFFE;
    mCnt[1]       = 32'hFFFF_FFFE;
    seq_q = '{14'h0001, 14'h0002};
    run_seq(1);
    vectors++;
    if (cnt[1] !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL cnt_saturate: got %h, expected ffffffff", cnt[1]);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      pulse_reset(s);
      for (int r = 0; r < 6; r++) begin
        seq_q.delete();
        repeat ($urandom_range(1, 4)) begin
          if (s == 0) seq_q.push_back(AW'($urandom_range(0, 511)));
          else        seq_q.push_back(AW'($urandom_range(0, D1 - 1)));
        end
        run_seq(s);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 2'b11;
    req  = 2'b00;
    addr = '0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_out_of_range();
    test_halt();
    test_reset_mid_wait();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
